// File: rtl/instr_ctrl_if.sv
// Bus between the instruction controller, its instruction ROM and the 8x16 register file.
// Protocol: ROM data is valid the cycle after imem_addr; wr_addr/wr_data are meaningful only while wr_en=1.
interface instr_ctrl_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_data;
    logic [2:0]          rd0_addr;
    logic [2:0]          rd1_addr;
    logic [15:0]         rd0_data;
    logic [15:0]         rd1_data;
    logic [2:0]          wr_addr;
    logic [15:0]         wr_data;
    logic                wr_en;

    modport master (
        output imem_addr, rd0_addr, rd1_addr, wr_addr, wr_data, wr_en,
        input  imem_data, rd0_data, rd1_data
    );

    modport slave (
        input  imem_addr, rd0_addr, rd1_addr, wr_addr, wr_data, wr_en,
        output imem_data, rd0_data, rd1_data
    );
endinterface

// File: rtl/instr_ctrl.sv
// Fetch/decode/execute/writeback controller for the 8x16 lab CPU: four cycles per
// instruction, drives the ROM address and the register file ports through one ALU.
module instr_ctrl #(
    parameter int PC_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    instr_ctrl_if.master  bus,
    output logic          halted,
    output logic [2:0]    dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] jmp_target;
    logic [15:0]         ir;
    logic [15:0]         result;
    logic [15:0]         alu_out;
    logic [3:0]          op;
    logic                writes_reg;

    assign op         = ir[15:12];
    assign writes_reg = (op >= 4'h1) && (op <= 4'h9);

    // Jump target is imm8, zero-extended or truncated to the PC width.
    if (PC_WIDTH >= 8) begin : g_wide_pc
        assign jmp_target = PC_WIDTH'(ir[7:0]);
    end else begin : g_narrow_pc
        assign jmp_target = ir[PC_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (op == OP_HALT) ? S_HALTED : S_WB;
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_out = 16'h0000;
        case (op)
            4'h1:    alu_out = bus.rd0_data + bus.rd1_data;
            4'h2:    alu_out = bus.rd0_data - bus.rd1_data;
            4'h3:    alu_out = bus.rd0_data & bus.rd1_data;
            4'h4:    alu_out = bus.rd0_data | bus.rd1_data;
            4'h5:    alu_out = bus.rd0_data ^ bus.rd1_data;
            4'h6:    alu_out = ~bus.rd0_data;
            4'h7:    alu_out = bus.rd0_data << bus.rd1_data[3:0];
            4'h8:    alu_out = bus.rd0_data >> bus.rd1_data[3:0];
            4'h9:    alu_out = {8'h00, ir[7:0]};
            default: alu_out = 16'h0000;
        endcase
    end

    // The write lands at the end of WB, so an operand equal to dst reads the old value in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            ir     <= 16'h0000;
            result <= 16'h0000;
        end else begin
            case (state)
                S_DECODE: ir     <= bus.imem_data;
                S_EXEC:   result <= alu_out;
                S_WB:     pc     <= (op == OP_JMP) ? jmp_target : pc + PC_WIDTH'(1);
                default:  ;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.rd0_addr  = ir[8:6];
    assign bus.rd1_addr  = ir[5:3];
    assign bus.wr_addr   = ir[11:9];
    assign bus.wr_data   = result;
    assign bus.wr_en     = (state == S_WB) && writes_reg;
    assign halted        = (state == S_HALTED);
    assign dbg_state     = state;
endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: ROM and register file models around the DUT, an ISA-level
// reference interpreter producing expected writes, plus directed boundary scenarios.
module tb_instr_ctrl;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        run4 = 1'b0;
    logic        init_req = 1'b0;
    logic        halted, halted4;
    logic [2:0]  dbg_state, dbg_state4;
    logic [15:0] init_val [8];
    logic [15:0] regs [8];
    logic [15:0] m_regs [8];
    logic [15:0] rom [256];
    logic [18:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;

    instr_ctrl_if #(.PC_WIDTH(8)) bus ();
    instr_ctrl_if #(.PC_WIDTH(4)) bus4 ();

    instr_ctrl #(.PC_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus), .halted(halted), .dbg_state(dbg_state)
    );
    instr_ctrl #(.PC_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .run(run4), .bus(bus4), .halted(halted4), .dbg_state(dbg_state4)
    );

    always #5 clk = ~clk;

    // Synchronous ROM and register file around the 8-bit PC instance.
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 8; i++) regs[i] <= init_val[i];
        end else if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end
    assign bus.rd0_data  = regs[bus.rd0_addr];
    assign bus.rd1_data  = regs[bus.rd1_addr];
    assign bus4.imem_data = 16'h0000;
    assign bus4.rd0_data  = 16'h0000;
    assign bus4.rd1_data  = 16'h0000;

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [18:0] exp;
        if (bus.wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got addr=%0d data=%h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== exp) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.wr_addr, bus.wr_data, exp[18:16], exp[15:0]);
                end
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 8; i++) init_val[i] = 16'($urandom);
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        init_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        rst = 1'b0;
    endtask

    // Instruction-level interpreter: fills exp_q and m_regs, returns executed count and HALT address.
    task automatic model_run(output int n, output logic [7:0] hpc);
        int pc;
        longint a, b, r;
        int op, d, s0, s1, sh;
        bit done, wr;
        logic [15:0] ins;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = init_val[i];
        pc = 0; n = 0; done = 0; hpc = 8'h00;
        while (!done && n < 1000) begin
            ins = rom[pc];
            op = int'(ins[15:12]); d = int'(ins[11:9]); s0 = int'(ins[8:6]); s1 = int'(ins[5:3]);
            a = longint'(m_regs[s0]); b = longint'(m_regs[s1]); sh = int'(b % 16);
            wr = 1; r = 0;
            case (op)
                1: r = (a + b) % 65536;
                2: r = (a - b + 65536) % 65536;
                3: r = a & b;
                4: r = a | b;
                5: r = a ^ b;
                6: r = 65535 - a;
                7: r = (a * (longint'(1) << sh)) % 65536;
                8: r = a / (longint'(1) << sh);
                9: r = longint'(ins[7:0]);
                default: wr = 0;
            endcase
            if (op == 15) begin
                done = 1;
                hpc = 8'(pc);
            end else begin
                if (wr) begin
                    m_regs[d] = 16'(r);
                    exp_q.push_back({3'(d), 16'(r)});
                end
                pc = (op == 10) ? int'(ins[7:0]) : (pc + 1) % 256;
                n++;
            end
        end
    endtask

    task automatic exec_program(output int cyc, output bit ok);
        run = 1'b1;
        cyc = 0;
        ok = 0;
        while (!ok && cyc < 600) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (halted === 1'b1) ok = 1;
        end
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        #3;
        checks++;
        if (bus.imem_addr !== 8'h00 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got imem_addr=%h wr_en=%b expected 00 0", bus.imem_addr, bus.wr_en);
        end
        checks++;
        if ({bus.wr_addr, bus.rd0_addr, bus.rd1_addr, bus.wr_data} !== 25'h0) begin
            errors++;
            $display("FAIL reset_addr got wr=%0d rd0=%0d rd1=%0d data=%h expected 0", bus.wr_addr, bus.rd0_addr, bus.rd1_addr, bus.wr_data);
        end
        checks++;
        if (halted !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got halted=%b state=%0d expected 0 0", halted, dbg_state);
        end
    endtask

    task automatic test_first_ldi();
        logic exp_en;
        clear_rom();
        rom[0] = 16'h9205;
        rand_regs();
        exp_q.delete();
        exp_q.push_back({3'd1, 16'h0005});
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_en = (c == 4);
            checks++;
            if (bus.wr_en !== exp_en) begin
                errors++;
                $display("FAIL ldi_wr_en cycle %0d got %b expected %b", c, bus.wr_en, exp_en);
            end
        end
        checks++;
        if (bus.wr_addr !== 3'd1 || bus.wr_data !== 16'h0005) begin
            errors++;
            $display("FAIL ldi_wb got addr=%0d data=%h expected 1 0005", bus.wr_addr, bus.wr_data);
        end
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.imem_addr !== 8'h01 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL ldi_pc got pc=%h state=%0d expected 01 0", bus.imem_addr, dbg_state);
        end
    endtask

    task automatic test_sub_chain();
        int n, cyc;
        bit ok;
        logic [7:0] hpc;
        clear_rom();
        rom[0] = 16'h9205; rom[1] = 16'h9403; rom[2] = 16'h2650; rom[3] = 16'h2888; rom[4] = 16'hF000;
        rand_regs();
        model_run(n, hpc);
        do_reset();
        exec_program(cyc, ok);
        checks++;
        if (!ok || cyc != 20) begin
            errors++;
            $display("FAIL sub_cycles got ok=%0d cycles=%0d expected 1 20", ok, cyc);
        end
        checks++;
        if (regs[3] !== 16'h0002 || regs[4] !== 16'hFFFE) begin
            errors++;
            $display("FAIL sub_result got r3=%h r4=%h expected 0002 FFFE", regs[3], regs[4]);
        end
        checks++;
        if (exp_q.size() != 0 || bus.imem_addr !== hpc) begin
            errors++;
            $display("FAIL sub_end got pending=%0d pc=%h expected 0 %h", exp_q.size(), bus.imem_addr, hpc);
        end
    endtask

    task automatic test_jmp();
        int n, cyc, w0;
        bit ok;
        logic [7:0] hpc;
        clear_rom();
        rom[4] = 16'hA010;
        rom[16] = 16'hF000;
        rand_regs();
        model_run(n, hpc);
        do_reset();
        w0 = wr_count;
        exec_program(cyc, ok);
        checks++;
        if (!ok || cyc != 24 || bus.imem_addr !== 8'h10) begin
            errors++;
            $display("FAIL jmp_target got ok=%0d cycles=%0d pc=%h expected 1 24 10", ok, cyc, bus.imem_addr);
        end
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL jmp_no_write got %0d pulses expected 0", wr_count - w0);
        end
    endtask

    task automatic test_halt();
        int n, cyc;
        bit ok;
        logic [7:0] hpc;
        clear_rom();
        rom[3] = 16'hF000;
        rand_regs();
        model_run(n, hpc);
        do_reset();
        exec_program(cyc, ok);
        checks++;
        if (!ok || cyc != 16) begin
            errors++;
            $display("FAIL halt_cycles got ok=%0d cycles=%0d expected 1 16", ok, cyc);
        end
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || bus.wr_en !== 1'b0 || bus.imem_addr !== 8'h03) begin
                errors++;
                $display("FAIL halt_hold got halted=%b wr_en=%b pc=%h expected 1 0 03", halted, bus.wr_en, bus.imem_addr);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL halt_clear got halted=%b state=%0d expected 0 0", halted, dbg_state);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run_drop();
        int n, cyc;
        bit ok;
        logic [7:0] hpc;
        clear_rom();
        rom[0] = 16'h9207; rom[1] = 16'h9409; rom[2] = 16'h1650; rom[3] = 16'h9A01; rom[4] = 16'hF000;
        rand_regs();
        model_run(n, hpc);
        do_reset();
        run = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_DECODE) begin
            errors++;
            $display("FAIL drop_decode got state=%0d expected %0d", dbg_state, ST_DECODE);
        end
        run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd3) begin
            errors++;
            $display("FAIL drop_wb got wr_en=%b addr=%0d expected 1 3", bus.wr_en, bus.wr_addr);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || bus.imem_addr !== 8'h03) begin
            errors++;
            $display("FAIL drop_idle got state=%0d pc=%h expected 0 03", dbg_state, bus.imem_addr);
        end
        exec_program(cyc, ok);
        checks++;
        if (!ok || cyc != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_resume got ok=%0d cycles=%0d pending=%0d expected 1 8 0", ok, cyc, exp_q.size());
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (regs[r] !== m_regs[r]) begin
                errors++;
                $display("FAIL drop_reg r%0d got %h expected %h", r, regs[r], m_regs[r]);
            end
        end
    endtask

    task automatic test_rst_exec();
        int w0;
        clear_rom();
        rom[0] = 16'h1650;
        rand_regs();
        exp_q.delete();
        do_reset();
        run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_EXEC) begin
            errors++;
            $display("FAIL rst_exec_state got %0d expected %0d", dbg_state, ST_EXEC);
        end
        w0 = wr_count;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.imem_addr, bus.wr_addr, bus.rd0_addr, bus.rd1_addr, bus.wr_data, bus.wr_en, halted, dbg_state} !== 40'h0) begin
            errors++;
            $display("FAIL rst_exec_async got pc=%h wr=%0d rd0=%0d rd1=%0d data=%h en=%b state=%0d expected all 0",
                     bus.imem_addr, bus.wr_addr, bus.rd0_addr, bus.rd1_addr, bus.wr_data, bus.wr_en, dbg_state);
        end
        repeat (3) @(posedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_count != w0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_exec_nowrite got pulses=%0d state=%0d expected 0 0", wr_count - w0, dbg_state);
        end
    endtask

    task automatic test_pc_wrap();
        logic [3:0] exp_pc;
        do_reset();
        run4 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_pc = 4'(i % 16);
            checks++;
            if (bus4.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL wrap_pc instr %0d got %h expected %h", i, bus4.imem_addr, exp_pc);
            end
            repeat (3) @(posedge clk);
        end
        run4 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        int n, cyc;
        bit ok;
        logic [7:0] hpc;
        logic [15:0] ins;
        logic [3:0] op;
        for (int p = 0; p < 6; p++) begin
            clear_rom();
            for (int i = 0; i < 20; i++) begin
                op = 4'($urandom_range(0, 14));
                ins = {op, 12'($urandom)};
                if (op == 4'hA) ins[7:0] = 8'($urandom_range(i + 1, 20));
                rom[i] = ins;
            end
            rom[20] = 16'hF000;
            rand_regs();
            model_run(n, hpc);
            do_reset();
            exec_program(cyc, ok);
            checks++;
            if (!ok || cyc != 4 * (n + 1) || bus.imem_addr !== hpc) begin
                errors++;
                $display("FAIL rand%0d_end got ok=%0d cycles=%0d pc=%h expected 1 %0d %h", p, ok, cyc, bus.imem_addr, 4 * (n + 1), hpc);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL rand%0d_pending got %0d writes outstanding expected 0", p, exp_q.size());
            end
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (regs[r] !== m_regs[r]) begin
                    errors++;
                    $display("FAIL rand%0d_reg r%0d got %h expected %h", p, r, regs[r], m_regs[r]);
                end
            end
        end
    endtask

    initial begin
        clear_rom();
        rand_regs();
        test_reset();
        test_first_ldi();
        test_sub_chain();
        test_jmp();
        test_halt();
        test_run_drop();
        test_rst_exec();
        test_pc_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
